sipo_demux8: RTL and testbench



---
 rtl/sipo_demux8_pkg.sv | 17 +
 rtl/sipo_demux8_demux1_8.sv | 22 ++
 rtl/sipo_demux8.sv | 173 +++++++++++++++++
 tb/tb_sipo_demux8.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_demux8_pkg.sv
// Shared definitions for the sipo_demux8 serial-to-parallel collector.
// State encodings, default word width and the matching index width.
// Optional feature macro: SIPO_PARITY_EN (adds the PARITY state).
package sipo_demux8_pkg;

  // Collector states. PARITY is only reachable when SIPO_PARITY_EN is defined,
  // but the encoding is fixed so both builds share one state type.
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PARITY  = 2'd1,
    FULL    = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_IDX_W = $clog2(DEF_WIDTH);

endpackage : sipo_demux8_pkg

// File: rtl/sipo_demux8_demux1_8.sv
// Combinational 1:N write-enable decoder: turns a bit index plus an enable
// into a one-hot write-enable vector for the word register.
module demux1_8 #(
  parameter int N     = sipo_demux8_pkg::DEF_WIDTH,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N-1:0]     we_o
);

  // One-hot decode of the index, all zeros when not enabled.
  always_comb begin
    // NOTE: assigning a default before any conditional write keeps this block
    // purely combinational; a path that leaves we_o unassigned would infer a latch.
    we_o = '0;
    if (en_i) begin
      we_o[idx_i] = 1'b1;
    end
  end

endmodule : demux1_8

// File: rtl/sipo_demux8.sv
// sipo_demux8: serial-to-parallel collector (registered 1:WIDTH demux).
// Each accepted serial bit is written into one bit of a word register chosen
// by a bit counter; a complete word is offered on dout with valid/ready.
// Optional feature: define SIPO_PARITY_EN to append an even-parity bit after
// each word and report a mismatch on parity_err. Without it parity_err is 0.
module sipo_demux8
  import sipo_demux8_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit LSB_FIRST = 1'b1,
  localparam int IDX_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [IDX_W-1:0] bit_cnt,
  output logic             parity_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  // Registered state and its next-state values.
  state_e           state_q,   state_d;
  logic [IDX_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] word_q,    word_d;
  logic [WIDTH-1:0] dout_q,    dout_d;
`ifdef SIPO_PARITY_EN
  logic             perr_q,    perr_d;
`endif

  // Datapath helpers.
  logic             accept;
  logic             collect_acc;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] we;
  logic [WIDTH-1:0] word_merged;

  // Handshake outputs are decoded straight from the state register.
  assign din_ready  = (state_q == COLLECT) || (state_q == PARITY);
  assign dout_valid = (state_q == FULL);
  assign dout       = dout_q;
  assign bit_cnt    = bit_cnt_q;

`ifdef SIPO_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign accept      = din_valid & din_ready;
  assign collect_acc = accept & (state_q == COLLECT);

  // Serial order: k-th bit lands in bit k (LSB first) or bit WIDTH-1-k.
  assign idx = LSB_FIRST ? bit_cnt_q : (LAST_IDX - bit_cnt_q);

  demux1_8 #(
    .N     (WIDTH),
    .IDX_W (IDX_W)
  ) u_demux (
    .idx_i (idx),
    .en_i  (collect_acc),
    .we_o  (we)
  );

  // Merge the incoming bit into the addressed word bit; others hold.
  always_comb begin
    word_merged = word_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (we[i]) begin
        word_merged[i] = din;
      end
    end
  end

  // Next-state logic for the FSM, bit counter, word and output registers.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    word_d    = word_q;
    dout_d    = dout_q;
`ifdef SIPO_PARITY_EN
    perr_d    = perr_q;
`endif

    case (state_q)
      COLLECT: begin
        if (accept) begin
          word_d = word_merged;
          if (bit_cnt_q == LAST_IDX) begin
            // Final bit is merged into dout on the same edge it arrives.
            bit_cnt_d = '0;
            dout_d    = word_merged;
`ifdef SIPO_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = FULL;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      PARITY: begin
`ifdef SIPO_PARITY_EN
        // The accepted bit is the even-parity bit for the word now in dout.
        if (accept) begin
          perr_d  = (^dout_q) ^ din;
          state_d = FULL;
        end
`else
        state_d = COLLECT;
`endif
      end

      FULL: begin
        // Handoff cycle: din_ready is low, so no bit is taken here.
        if (dout_ready) begin
          state_d = COLLECT;
`ifdef SIPO_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
      end

      default: begin
        state_d = COLLECT;
      end
    endcase

    // Abort: drop the partial word and any pending output, keep dout data.
    if (clr) begin
      state_d   = COLLECT;
      bit_cnt_d = '0;
      word_d    = '0;
`ifdef SIPO_PARITY_EN
      perr_d    = 1'b0;
`endif
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: the word register is reset along with the control state; it is a
    // single flop vector, not a memory array, so the reset costs nothing odd.
    if (rst) begin
      state_q   <= COLLECT;
      bit_cnt_q <= '0;
      word_q    <= '0;
      dout_q    <= '0;
`ifdef SIPO_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      word_q    <= word_d;
      dout_q    <= dout_d;
`ifdef SIPO_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

endmodule : sipo_demux8

// File: tb/tb_sipo_demux8.sv
// Directed self-checking bench for sipo_demux8. Two instances share stimulus:
// dut (LSB_FIRST=1) and dut_msb (LSB_FIRST=0). Parity expectations follow
// the SIPO_PARITY_EN build macro.
module tb_sipo_demux8;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       din;
  logic       din_valid;
  logic       dout_ready;

  logic       din_ready,  din_ready_m;
  logic [7:0] dout,       dout_m;
  logic       dout_valid, dout_valid_m;
  logic [2:0] bit_cnt,    bit_cnt_m;
  logic       parity_err, parity_err_m;

  int n_cmp = 0;
  int n_err = 0;

  sipo_demux8 #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .bit_cnt    (bit_cnt),
    .parity_err (parity_err)
  );

  sipo_demux8 #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready_m),
    .dout       (dout_m),
    .dout_valid (dout_valid_m),
    .dout_ready (dout_ready),
    .bit_cnt    (bit_cnt_m),
    .parity_err (parity_err_m)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send 8 serial bits on consecutive cycles; w[k] is the k-th serial bit.
  task automatic send_bits(input logic [7:0] w);
    for (int k = 0; k < 8; k++) begin
      din       = w[k];
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
  endtask

  // In the parity build, send the parity bit; then check parity_err.
  task automatic complete_word(input logic p, input logic exp_err);
`ifdef SIPO_PARITY_EN
    check("parity_state_no_valid", 32'(dout_valid), 32'(0));
    check("parity_state_ready", 32'(din_ready), 32'(1));
    din       = p;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check("parity_err", 32'(parity_err), 32'(exp_err));
`else
    check("parity_err_tied", 32'(parity_err), 32'(0));
`endif
  endtask

  initial begin
    rst        = 1'b1;
    clr        = 1'b0;
    din        = 1'b0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_dout_valid", 32'(dout_valid), 32'(0));
    check("rst_bit_cnt", 32'(bit_cnt), 32'(0));
    check("rst_din_ready", 32'(din_ready), 32'(1));
    check("rst_parity_err", 32'(parity_err), 32'(0));

    // Stream 1,0,1,1,0,0,1,0: LSB first -> 4D, MSB first -> B2
    begin
      logic [7:0] s;
      s = 8'h4D;
      for (int k = 0; k < 7; k++) begin
        din       = s[k];
        din_valid = 1'b1;
        tick();
      end
      check("t1_cnt7", 32'(bit_cnt), 32'(7));
      check("t1_no_valid_before_8th", 32'(dout_valid), 32'(0));
      din = s[7];
      tick();
      din_valid = 1'b0;
    end
    complete_word(1'b0, 1'b0);
    check("t1_valid", 32'(dout_valid), 32'(1));
    check("t1_dout_lsb", 32'(dout), 32'h4D);
    check("t1_valid_msb", 32'(dout_valid_m), 32'(1));
    check("t1_dout_msb", 32'(dout_m), 32'hB2);
    check("t1_cnt_wrap", 32'(bit_cnt), 32'(0));
    check("t1_full_not_ready", 32'(din_ready), 32'(0));
    tick();
    check("t1_valid_one_cycle", 32'(dout_valid), 32'(0));
    check("t1_dout_hold", 32'(dout), 32'h4D);
    check("t1_ready_again", 32'(din_ready), 32'(1));

    // Backpressure: word held for 5 cycles with din_valid high
    dout_ready = 1'b0;
    send_bits(8'h4D);
    complete_word(1'b0, 1'b0);
    din       = 1'b1;
    din_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("t3_din_ready_low", 32'(din_ready), 32'(0));
      check("t3_valid_held", 32'(dout_valid), 32'(1));
      check("t3_dout_stable", 32'(dout), 32'h4D);
      check("t3_cnt_held", 32'(bit_cnt), 32'(0));
      tick();
    end
    dout_ready = 1'b1;
    tick();
    check("t3_handoff_valid", 32'(dout_valid), 32'(0));
    check("t3_handoff_no_accept", 32'(bit_cnt), 32'(0));
    send_bits(8'hFF);
    complete_word(1'b0, 1'b0);
    check("t3_ff_valid", 32'(dout_valid), 32'(1));
    check("t3_ff_dout", 32'(dout), 32'hFF);
    tick();
    check("t3_ff_taken", 32'(dout_valid), 32'(0));

    // clr mid-word, bit in clr cycle dropped, then A5
    din       = 1'b1;
    din_valid = 1'b1;
    tick();
    tick();
    tick();
    check("t4_cnt3", 32'(bit_cnt), 32'(3));
    clr = 1'b1;
    tick();
    clr       = 1'b0;
    din_valid = 1'b0;
    check("t4_clr_cnt", 32'(bit_cnt), 32'(0));
    check("t4_clr_dout_kept", 32'(dout), 32'hFF);
    check("t4_clr_valid", 32'(dout_valid), 32'(0));
    send_bits(8'hA5);
    complete_word(1'b0, 1'b0);
    check("t4_a5_valid", 32'(dout_valid), 32'(1));
    check("t4_a5_dout", 32'(dout), 32'hA5);
    check("t4_a5_dout_msb", 32'(dout_m), 32'hA5);
    // clr while FULL drops valid but keeps the data
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t4_clr_full_valid", 32'(dout_valid), 32'(0));
    check("t4_clr_full_dout", 32'(dout), 32'hA5);

    // Gaps: din_valid alternating, word 3C
    begin
      logic [7:0] w;
      w = 8'h3C;
      for (int k = 0; k < 8; k++) begin
        din       = w[k];
        din_valid = 1'b1;
        tick();
        check("t5_cnt_accept", 32'(bit_cnt), 32'((k + 1) % 8));
        din_valid = 1'b0;
        din       = ~w[k];
        if (k < 7) begin
          tick();
          check("t5_cnt_gap", 32'(bit_cnt), 32'(k + 1));
        end
      end
    end
    complete_word(1'b0, 1'b0);
    check("t5_valid", 32'(dout_valid), 32'(1));
    check("t5_dout", 32'(dout), 32'h3C);
    check("t5_dout_msb", 32'(dout_m), 32'h3C);
    tick();

    // Wrong parity bit on 4D
    send_bits(8'h4D);
    complete_word(1'b1, 1'b1);
    check("t6_dout", 32'(dout), 32'h4D);
    check("t6_valid", 32'(dout_valid), 32'(1));
    tick();
    check("t6_perr_cleared", 32'(parity_err), 32'(0));
    check("t6_taken", 32'(dout_valid), 32'(0));

    // rst mid-word returns all reset values
    din       = 1'b1;
    din_valid = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    din_valid = 1'b0;
    check("t7_rst_cnt", 32'(bit_cnt), 32'(0));
    check("t7_rst_dout", 32'(dout), 32'h00);
    check("t7_rst_valid", 32'(dout_valid), 32'(0));
    check("t7_rst_ready", 32'(din_ready), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sipo_demux8
